// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared constants for the IF-stage fetch program-counter generator.
//   DEF_ADDR_W     : default fetch address width
//   DEF_RESET_VEC  : default first fetch address after reset
//   DEF_INST_BYTES : default PC increment (power of two, >= 1)
//   DEF_NUM_RD     : default number of redirect channels
//   STALL_W        : width of the pipeline stall vector
//   STALL_IF       : index of the IF stall bit inside the stall vector
// -----------------------------------------------------------------------------
package pc_pkg;
    localparam int          DEF_ADDR_W     = 32;
    localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
    localparam int          DEF_INST_BYTES = 4;
    localparam int          DEF_NUM_RD     = 2;
    localparam int          STALL_W        = 6;
    localparam int          STALL_IF       = 0;
endpackage

// File: rtl/pc_gen_rd_arb.sv
// -----------------------------------------------------------------------------
// rd_arb
// Purely combinational fixed-priority arbiter over the redirect channels.
// Channel 0 has the highest priority. The winning target is aligned to
// INST_BYTES by clearing its low bits; any set bit that was cleared raises
// win_misaligned.
// Ports:
//   rd_valid       in  NUM_RD          per-channel request
//   rd_addr        in  NUM_RD*ADDR_W   packed targets, channel i at [i*ADDR_W +: ADDR_W]
//   win_valid      out 1               some channel is requesting
//   win_addr       out ADDR_W          aligned target of the winning channel
//   win_misaligned out 1               winner's target had nonzero low bits
// -----------------------------------------------------------------------------
module rd_arb #(
    parameter int ADDR_W     = 32,
    parameter int INST_BYTES = 4,
    parameter int NUM_RD     = 2
) (
    input  logic [NUM_RD-1:0]        rd_valid,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic                     win_valid,
    output logic [ADDR_W-1:0]        win_addr,
    output logic                     win_misaligned
);
    // INST_BYTES is a power of two, so INST_BYTES-1 covers exactly the
    // offset bits (empty mask when INST_BYTES == 1).
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

    logic [ADDR_W-1:0] ch_addr [NUM_RD];
    logic [ADDR_W-1:0] raw_addr;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_unpack
        assign ch_addr[gi] = rd_addr[gi*ADDR_W +: ADDR_W];
    end

    // Scan from the lowest priority upward so the last hit (lowest index)
    // is the one that sticks.
    always_comb begin
        win_valid = 1'b0;
        raw_addr  = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (rd_valid[i]) begin
                win_valid = 1'b1;
                raw_addr  = ch_addr[i];
            end
        end
    end

    assign win_addr       = raw_addr & ~LOW_MASK;
    assign win_misaligned = win_valid && ((raw_addr & LOW_MASK) != '0);
endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Fetch program-counter generator for the IF stage. Issues a new fetch
// address every unstalled cycle, arbitrates prioritised redirects, holds a
// redirect that arrives during an IF stall until the stall clears, and
// pulses flush_if whenever the fetch stream is redirected.
// Ports:
//   clk        in  1               clock, rising edge
//   rst        in  1               asynchronous active-low reset
//   stall      in  STALL_W         pipeline stall vector, only the IF bit is used
//   rd_valid   in  NUM_RD          per-channel redirect request
//   rd_addr    in  NUM_RD*ADDR_W   packed redirect targets
//   pc         out ADDR_W          current fetch address
//   ce         out 1               fetch enable
//   flush_if   out 1               one-cycle pulse after a redirect is applied
//   rd_pending out 1               a captured redirect awaits the stall release
//   misaligned out 1               one-cycle pulse: applied/captured target was unaligned
// -----------------------------------------------------------------------------
module pc_gen
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
    parameter int                INST_BYTES = DEF_INST_BYTES,
    parameter int                NUM_RD     = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic [NUM_RD-1:0]        rd_valid,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0]        pc,
    output logic                     ce,
    output logic                     flush_if,
    output logic                     rd_pending,
    output logic                     misaligned
);
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pend_addr_reg;
    logic              ce_reg;
    logic              flush_reg;
    logic              pending_reg;
    logic              mis_reg;

    logic              win_valid;
    logic [ADDR_W-1:0] win_addr;
    logic              win_misaligned;
    logic              stall_if;
    logic              unused_stall;

    assign stall_if     = stall[STALL_IF];
    // Only the IF bit matters here; the rest of the vector is ignored.
    assign unused_stall = |stall;

    rd_arb #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES),
        .NUM_RD     (NUM_RD)
    ) u_rd_arb (
        .rd_valid       (rd_valid),
        .rd_addr        (rd_addr),
        .win_valid      (win_valid),
        .win_addr       (win_addr),
        .win_misaligned (win_misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg        <= RESET_VEC;
            pend_addr_reg <= '0;
            ce_reg        <= 1'b0;
            flush_reg     <= 1'b0;
            pending_reg   <= 1'b0;
            mis_reg       <= 1'b0;
        end else begin
            flush_reg <= 1'b0;
            mis_reg   <= 1'b0;
            if (!ce_reg) begin
                // First edge out of reset only enables fetch; inputs ignored.
                ce_reg <= 1'b1;
            end else if (win_valid) begin
                mis_reg <= win_misaligned;
                if (!stall_if) begin
                    pc_reg      <= win_addr;
                    flush_reg   <= 1'b1;
                    pending_reg <= 1'b0;
                end else begin
                    // Newest winner replaces any older captured target.
                    pend_addr_reg <= win_addr;
                    pending_reg   <= 1'b1;
                end
            end else if (pending_reg && !stall_if) begin
                pc_reg      <= pend_addr_reg;
                flush_reg   <= 1'b1;
                pending_reg <= 1'b0;
            end else if (!stall_if) begin
                pc_reg <= pc_reg + ADDR_W'(INST_BYTES);
            end
        end
    end

    assign pc         = pc_reg;
    assign ce         = ce_reg;
    assign flush_if   = flush_reg;
    assign rd_pending = pending_reg;
    assign misaligned = mis_reg;
endmodule
